// File: rtl/rv_trace_pkg.sv
// Shared types for the commit tracer: FSM state encoding and the
// buffered trace record. Record fields are sized to the widest supported
// configuration; narrower instances zero-extend on write and slice on read.
package rv_trace_pkg;

   localparam int TRACE_XLEN = 32;
   localparam int TRACE_TS_W = 16;

   typedef enum logic [1:0] {
      RUN    = 2'd0,
      ARMED  = 2'd1,
      FROZEN = 2'd2
   } trace_state_e;

   typedef struct packed {
      logic [TRACE_XLEN-1:0] pc;
      logic [4:0]            rd;
      logic [TRACE_XLEN-1:0] data;
      logic [TRACE_TS_W-1:0] ts;
   } trace_entry_t;

endpackage

// File: rtl/rv_trace_fifo.sv
// DEPTH-entry trace FIFO with a combinational head. overwrite drops the
// oldest entry in the same cycle as a push, so a full buffer keeps the
// newest DEPTH records (snapshot mode).
module rv_trace_fifo
   import rv_trace_pkg::*;
#(
   parameter  int DEPTH = 16,
   localparam int AW    = $clog2(DEPTH),
   localparam int CW    = AW + 1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          flush,
   input  logic          push,
   input  logic          pop,
   input  logic          overwrite,
   input  trace_entry_t  wdata,
   output trace_entry_t  head,
   output logic          full,
   output logic          empty,
   output logic [CW-1:0] count
);

   trace_entry_t  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          adv_rd;

   // Oldest entry leaves on a consumer pop or on a snapshot overwrite.
   assign adv_rd = pop || overwrite;

   // Storage has no reset; contents are only meaningful below count.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= wdata;
   end

   // Pointer and occupancy bookkeeping; pointers wrap modulo DEPTH.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push)   wr_ptr <= wr_ptr + 1'b1;
         if (adv_rd) rd_ptr <= rd_ptr + 1'b1;
         if (push && !adv_rd)      count <= count + 1'b1;
         else if (!push && adv_rd) count <= count - 1'b1;
      end
   end

   assign head  = mem[rd_ptr];
   assign full  = (count == CW'(DEPTH));
   assign empty = (count == '0);

endmodule

// File: rtl/rv_commit_tracer.sv
// Commit-trace capture: filters the writeback commit stream by rd mask,
// timestamps accepted commits and buffers them for a valid/ready consumer.
// Stream mode drops on full and counts drops; snapshot mode keeps the
// newest DEPTH commits and freezes once the trigger PC is captured.
module rv_commit_tracer
   import rv_trace_pkg::*;
#(
   parameter  int XLEN  = 32,
   parameter  int DEPTH = 16,
   parameter  int TS_W  = 16,
   parameter  int OVF_W = 16,
   localparam int CW    = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             commit_valid_i,
   input  logic [XLEN-1:0]  commit_pc_i,
   input  logic [4:0]       commit_rd_i,
   input  logic [XLEN-1:0]  commit_data_i,
   input  logic [31:0]      rd_mask_i,
   input  logic             mode_i,
   input  logic [XLEN-1:0]  trig_pc_i,
   input  logic             rearm_i,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [XLEN-1:0]  out_pc,
   output logic [4:0]       out_rd,
   output logic [XLEN-1:0]  out_data,
   output logic [TS_W-1:0]  out_ts,
   output logic [CW-1:0]    count,
   output logic [OVF_W-1:0] overflow_cnt,
   output logic             frozen
);

   trace_state_e  state;
   logic [TS_W-1:0] ts_cnt;
   logic          cap, trig;
   logic          push, pop, ovw, drop;
   logic          full, empty;
   trace_entry_t  wdata, head;

   assign cap  = commit_valid_i && rd_mask_i[commit_rd_i];
   assign trig = (state == ARMED) && cap && (commit_pc_i == trig_pc_i);

   assign wdata.pc   = TRACE_XLEN'(commit_pc_i);
   assign wdata.rd   = commit_rd_i;
   assign wdata.data = TRACE_XLEN'(commit_data_i);
   assign wdata.ts   = TRACE_TS_W'(ts_cnt);

   // Per-state FIFO control; a rearm cycle neither captures nor pops.
   always_comb begin
      out_valid = 1'b0;
      pop       = 1'b0;
      push      = 1'b0;
      ovw       = 1'b0;
      drop      = 1'b0;
      case (state)
         RUN: begin
            out_valid = !empty;
            pop       = out_valid && out_ready;
            push      = cap && (!full || pop);
            drop      = cap && full && !pop;
         end
         ARMED: begin
            push = cap;
            ovw  = cap && full;
         end
         FROZEN: begin
            out_valid = !empty;
            pop       = out_valid && out_ready;
         end
         default: ;
      endcase
      if (rearm_i) begin
         pop  = 1'b0;
         push = 1'b0;
         ovw  = 1'b0;
         drop = 1'b0;
      end
   end

   rv_trace_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .flush     (rearm_i),
      .push      (push),
      .pop       (pop),
      .overwrite (ovw),
      .wdata     (wdata),
      .head      (head),
      .full      (full),
      .empty     (empty),
      .count     (count)
   );

   // Mode FSM: rearm selects stream or snapshot, trigger capture freezes.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state  <= RUN;
         frozen <= 1'b0;
      end else if (rearm_i) begin
         state  <= mode_i ? ARMED : RUN;
         frozen <= 1'b0;
      end else if (trig) begin
         state  <= FROZEN;
         frozen <= 1'b1;
      end
   end

   // Free-running timestamp; deliberately survives rearm.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) ts_cnt <= '0;
      else       ts_cnt <= ts_cnt + 1'b1;
   end

   // Saturating count of stream-mode drops.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)                             overflow_cnt <= '0;
      else if (rearm_i)                      overflow_cnt <= '0;
      else if (drop && overflow_cnt != '1)   overflow_cnt <= overflow_cnt + 1'b1;
   end

   // Data outputs read zero whenever no entry is presented.
   assign out_pc   = out_valid ? head.pc[XLEN-1:0]   : '0;
   assign out_rd   = out_valid ? head.rd             : '0;
   assign out_data = out_valid ? head.data[XLEN-1:0] : '0;
   assign out_ts   = out_valid ? head.ts[TS_W-1:0]   : '0;

endmodule

// File: tb/tb_rv_commit_tracer.sv
// Directed bench for rv_commit_tracer: stream, overflow, snapshot,
// masked trigger, rearm/reset and timestamp wrap (second instance, TS_W=4).
module tb_rv_commit_tracer;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        commit_valid_i = 1'b0;
   logic [31:0] commit_pc_i = '0;
   logic [4:0]  commit_rd_i = '0;
   logic [31:0] commit_data_i = '0;
   logic [31:0] rd_mask_i = '0;
   logic        mode_i = 1'b0;
   logic [31:0] trig_pc_i = '0;
   logic        rearm_i = 1'b0;
   logic        out_ready = 1'b0;

   logic        out_valid, frozen;
   logic [31:0] out_pc, out_data;
   logic [4:0]  out_rd;
   logic [15:0] out_ts, overflow_cnt;
   logic [4:0]  count;

   logic        out_valid4, frozen4;
   logic [31:0] out_pc4, out_data4;
   logic [4:0]  out_rd4;
   logic [3:0]  out_ts4;
   logic [15:0] overflow_cnt4;
   logic [4:0]  count4;

   int n_cmp = 0;
   int n_err = 0;
   int ts_m  = 0;

   always #5 clk = ~clk;

   rv_commit_tracer dut (
      .clk(clk), .reset(reset), .commit_valid_i(commit_valid_i), .commit_pc_i(commit_pc_i),
      .commit_rd_i(commit_rd_i), .commit_data_i(commit_data_i), .rd_mask_i(rd_mask_i),
      .mode_i(mode_i), .trig_pc_i(trig_pc_i), .rearm_i(rearm_i), .out_valid(out_valid),
      .out_ready(out_ready), .out_pc(out_pc), .out_rd(out_rd), .out_data(out_data),
      .out_ts(out_ts), .count(count), .overflow_cnt(overflow_cnt), .frozen(frozen)
   );

   rv_commit_tracer #(.TS_W(4)) dut4 (
      .clk(clk), .reset(reset), .commit_valid_i(commit_valid_i), .commit_pc_i(commit_pc_i),
      .commit_rd_i(commit_rd_i), .commit_data_i(commit_data_i), .rd_mask_i(rd_mask_i),
      .mode_i(mode_i), .trig_pc_i(trig_pc_i), .rearm_i(rearm_i), .out_valid(out_valid4),
      .out_ready(out_ready), .out_pc(out_pc4), .out_rd(out_rd4), .out_data(out_data4),
      .out_ts(out_ts4), .count(count4), .overflow_cnt(overflow_cnt4), .frozen(frozen4)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // One clock edge; ts_m mirrors the DUT timestamp (edges since release).
   task automatic step();
      @(posedge clk);
      if (!reset) ts_m++;
      #1;
   endtask

   task automatic commit(input logic [31:0] pc, input logic [4:0] rd, input logic [31:0] data);
      commit_valid_i = 1'b1;
      commit_pc_i    = pc;
      commit_rd_i    = rd;
      commit_data_i  = data;
      step();
      commit_valid_i = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      ts_m  = 0;
   endtask

   int t_a, t_b;

   initial begin
      // ---- reset values ----
      do_reset();
      chk("rst_valid", out_valid, 0);
      chk("rst_count", count, 0);
      chk("rst_ovf", overflow_cnt, 0);
      chk("rst_frozen", frozen, 0);
      chk("rst_data", out_data, 0);
      chk("rst_ts", out_ts, 0);

      // ---- 1: stream basic ----
      rd_mask_i = 32'h10;
      out_ready = 1'b1;
      t_a = ts_m;
      commit(32'h100, 5'd4, 32'd7);
      chk("s1_valid_a", out_valid, 1);
      chk("s1_rd_a", out_rd, 4);
      chk("s1_data_a", out_data, 7);
      chk("s1_ts_a", out_ts, t_a);
      step();
      chk("s1_valid_gap", out_valid, 0);
      t_b = ts_m;
      commit(32'h108, 5'd4, 32'd9);
      chk("s1_data_b", out_data, 9);
      chk("s1_ts_b", out_ts, t_a + 2);
      chk("s1_ts_b_model", out_ts, t_b);
      commit(32'h10c, 5'd5, 32'd3);
      chk("s1_rd5_dropped_valid", out_valid, 0);
      chk("s1_rd5_dropped_count", count, 0);

      // ---- 2: overflow ----
      do_reset();
      out_ready = 1'b0;
      t_a = ts_m;
      for (int i = 0; i < 20; i++) commit(32'h200 + 4 * i, 5'd4, 32'd100 + i);
      chk("s2_count", count, 16);
      chk("s2_ovf", overflow_cnt, 4);
      chk("s2_head_data", out_data, 100);
      chk("s2_head_pc", out_pc, 32'h200);
      chk("s2_head_ts", out_ts, t_a);
      out_ready = 1'b1;
      commit(32'h300, 5'd4, 32'd200);
      chk("s2_pp_count", count, 16);
      chk("s2_pp_ovf", overflow_cnt, 4);
      chk("s2_pp_head", out_data, 101);
      out_ready = 1'b0;

      // ---- 3: snapshot ----
      mode_i = 1'b1;
      trig_pc_i = 32'h40;
      rearm_i = 1'b1;
      step();
      rearm_i = 1'b0;
      chk("s3_rearm_count", count, 0);
      chk("s3_rearm_ovf", overflow_cnt, 0);
      chk("s3_rearm_valid", out_valid, 0);
      out_ready = 1'b1;
      for (int i = 0; i < 16; i++) commit(32'(4 * i), 5'd4, 32'(i));
      chk("s3_armed_valid", out_valid, 0);
      chk("s3_armed_count", count, 16);
      chk("s3_armed_frozen", frozen, 0);
      commit(32'h40, 5'd4, 32'd16);
      out_ready = 1'b0;
      chk("s3_frozen", frozen, 1);
      chk("s3_frz_count", count, 16);
      chk("s3_frz_valid", out_valid, 1);
      chk("s3_frz_ovf", overflow_cnt, 0);
      for (int i = 0; i < 3; i++) commit(32'h44 + 4 * i, 5'd4, 32'd17 + i);
      chk("s3_nocap_count", count, 16);
      out_ready = 1'b1;
      for (int i = 0; i < 16; i++) begin
         chk("s3_drain_valid", out_valid, 1);
         chk("s3_drain_pc", out_pc, 4 * (i + 1));
         step();
      end
      chk("s3_empty_valid", out_valid, 0);
      chk("s3_empty_frozen", frozen, 1);
      out_ready = 1'b0;

      // ---- 4: masked trigger ----
      rd_mask_i = ~32'h10;
      rearm_i = 1'b1;
      step();
      rearm_i = 1'b0;
      commit(32'h40, 5'd4, 32'hAA);
      chk("s4_frozen", frozen, 0);
      chk("s4_valid", out_valid, 0);
      chk("s4_count", count, 0);
      for (int i = 0; i < 4; i++) commit(32'h10 + 4 * i, 5'd3, 32'(i));
      commit(32'h40, 5'd3, 32'h55);
      chk("s4_trig_frozen", frozen, 1);
      chk("s4_trig_count", count, 5);
      chk("s4_trig_head", out_pc, 32'h10);

      // ---- 5: rearm mid-drain, then async reset ----
      mode_i = 1'b0;
      rearm_i = 1'b1;
      commit(32'h80, 5'd3, 32'h77);
      rearm_i = 1'b0;
      chk("s5_count", count, 0);
      chk("s5_valid", out_valid, 0);
      chk("s5_frozen", frozen, 0);
      commit(32'h90, 5'd3, 32'd1);
      chk("s5_run_valid", out_valid, 1);
      chk("s5_run_count", count, 1);
      for (int i = 0; i < 17; i++) commit(32'hA0 + 4 * i, 5'd3, 32'd2 + i);
      chk("s5_ovf", overflow_cnt, 2);
      @(posedge clk);
      #3 reset = 1'b1;
      #1;
      chk("s5_arst_count", count, 0);
      chk("s5_arst_valid", out_valid, 0);
      chk("s5_arst_data", out_data, 0);
      chk("s5_arst_ovf", overflow_cnt, 0);
      @(negedge clk);
      reset = 1'b0;
      ts_m  = 0;

      // ---- 6: timestamp wrap (dut4 has TS_W=4) ----
      rd_mask_i = '1;
      out_ready = 1'b0;
      for (int i = 0; i < 15; i++) step();
      commit(32'h500, 5'd1, 32'd1);
      step();
      commit(32'h504, 5'd2, 32'd2);
      chk("s6_count4", count4, 2);
      chk("s6_ts4_a", out_ts4, 15);
      chk("s6_ts16_a", out_ts, 15);
      out_ready = 1'b1;
      step();
      chk("s6_ts4_b", out_ts4, 1);
      chk("s6_ts16_b", out_ts, 17);
      chk("s6_pc4_b", out_pc4, 32'h504);
      out_ready = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/rv_commit_tracer.md
Name: rv_commit_tracer

Overview:
- Parametrised commit-trace capture block that sits beside the pipelined RV core.
- Consumes the writeback commit stream (valid, pc, rd, data) and filters it with a per-register mask.
- Timestamps each accepted commit and buffers it in a DEPTH-entry FIFO.
- Presents entries on a valid/ready port for the UVM monitor or scoreboard.
- Modes: continuous stream (drop-on-full with overflow count) and pre-trigger snapshot (circular overwrite, freeze on PC match).

Parameters:
XLEN, 32, commit data and PC width
DEPTH, 16, FIFO entries; power of two, minimum 2
TS_W, 16, timestamp width; wraps modulo 2^TS_W
OVF_W, 16, overflow counter width; saturates

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
commit_valid_i  in  1  commit strobe from WB
commit_pc_i  in  XLEN  committed instruction PC
commit_rd_i  in  5  destination register
commit_data_i  in  XLEN  writeback value
rd_mask_i  in  32  bit n=1 enables capture of commits to rd n
mode_i  in  1  0=stream, 1=snapshot; sampled only on rearm_i
trig_pc_i  in  XLEN  snapshot trigger PC
rearm_i  in  1  pulse: flush FIFO, enter mode selected by mode_i
out_valid  out  1  head entry available
out_ready  in  1  consumer accepts head
out_pc  out  XLEN  head PC
out_rd  out  5  head rd
out_data  out  XLEN  head data
out_ts  out  TS_W  head timestamp
count  out  $clog2(DEPTH)+1  occupancy
overflow_cnt  out  OVF_W  dropped commits (stream mode)
frozen  out  1  snapshot captured, awaiting drain/rearm

Behaviour:
- Reset values:
  - state=RUN; wr/rd pointers 0; count 0; timestamp counter 0; overflow_cnt 0.
  - out_valid 0; frozen 0; out_* data outputs 0.
- Timestamp: free-running, +1 every cycle after reset release, wraps to 0.
- Capture qualifier cap = commit_valid_i && rd_mask_i[commit_rd_i].
  - Entry stored = {pc, rd, data, ts_current}.
- FIFO: storage written on the clk edge.
  - Head is read combinationally from storage at rd pointer, so a captured entry appears on out_* the cycle after capture.
  - Pointers wrap modulo DEPTH.
- Pop = out_valid && out_ready.
- States:
  - RUN (stream):
    - out_valid = (count!=0).
    - cap && !full → push.
    - cap && full && !pop → drop; overflow_cnt++ (saturates at all-ones).
    - cap && full && pop → push and pop in the same cycle; count unchanged, no drop.
    - Simultaneous push/pop when empty: push only (no bypass); count→1.
  - ARMED (snapshot):
    - out_valid forced 0 and out_ready ignored.
    - cap → push. When full, the oldest entry is overwritten: rd pointer advances, count stays DEPTH, overflow_cnt unchanged.
    - cap && commit_pc_i==trig_pc_i → that entry is pushed, then next state FROZEN.
    - A non-captured commit (mask bit 0) at trig_pc does not trigger.
  - FROZEN:
    - No further captures.
    - out_valid = (count!=0); drains by normal pops.
    - frozen=1; stays after drain until rearm_i.
- rearm_i (any state, highest priority after reset):
  - Next cycle: pointers 0, count 0, overflow_cnt 0.
  - state = mode_i ? ARMED : RUN.
  - A commit in the rearm cycle is discarded.
  - The timestamp counter is not cleared.
- Reset asserted mid-operation: immediate return to reset values. Storage contents need not be cleared.
- Output data is stable while out_valid && !out_ready. A write never targets the head slot while out_valid=1, except for the overwrite in ARMED, where out_valid=0.

Decomposition:
- Package rv_trace_pkg:
  - typedef trace_state_e {RUN, ARMED, FROZEN}.
  - struct trace_entry_t {pc, rd, data, ts}, parametrised via package-level XLEN/TS_W localparams.
- One natural sub-module, rv_trace_fifo:
  - DEPTH-entry FIFO with push, pop and overwrite_oldest inputs.
  - Outputs full/empty/count, with a combinational head.
- The top level holds the mode FSM, qualifier, timestamp and overflow counter.

Test Plan:
1. Stream basic: mask=0x10; commits to rd4 data 7, 9, and to rd5 data 3; out_ready=1 → exactly two entries, (rd4,7) then (rd4,9), each out_valid the cycle after its commit; ts differ by the commit spacing.
2. Overflow: DEPTH=16, out_ready=0, 20 captured commits → count=16, overflow_cnt=4, head = 1st commit. Then one cycle with pop and capture together → count stays 16, overflow_cnt stays 4.
3. Snapshot: rearm with mode=1, trig_pc=0x40; 20 captured commits with PC 0x00..0x4C step 4 → frozen=1, count=16, drained PCs 0x04..0x40 in order, nothing after 0x40.
4. Trigger masked: mode=1, trig_pc=0x40 committed with rd masked off → remains ARMED, frozen=0, out_valid=0.
5. Rearm/reset mid-drain: FROZEN with count=5, pulse rearm (mode=0) → next cycle count=0, out_valid=0, state RUN. Assert reset asynchronously mid-cycle → outputs zeroed before the next edge.
6. Timestamp wrap: TS_W=4; capture at cycles 15 and 17 → out_ts 15 then 1.
